// File: rtl/input_fm_loader.sv
// Fill engine for the 4-bank input feature-map tile buffer.
// Turns a channel/row/column pixel stream into buffer write-port transactions.
module input_fm_loader #(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int Tm    = 16,
    parameter int Tr    = 64,
    parameter int Tc    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_m,
    input  logic [CNT_W-1:0] cfg_r,
    input  logic [CNT_W-1:0] cfg_c,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    wr_data,
    output logic [AW-1:0]    wr_addr,
    output logic             wr_ena,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
    } state_t;

    localparam logic [AW-1:0]    CHAN_STEP = AW'(Tr * Tc);
    localparam logic [AW-1:0]    ROW_STEP  = AW'(Tc);
    localparam logic [CNT_W-1:0] MAX_M     = CNT_W'(Tm);
    localparam logic [CNT_W-1:0] MAX_R     = CNT_W'(Tr);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(Tc);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cfg_m_q, cfg_m_d;
    logic [CNT_W-1:0] cfg_r_q, cfg_r_d;
    logic [CNT_W-1:0] cfg_c_q, cfg_c_d;
    logic [CNT_W-1:0] m_q, m_d;
    logic [CNT_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [AW-1:0]    chan_base_q, chan_base_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             wr_ena_q, wr_ena_d;

    logic hs;
    logic last_c;
    logic last_r;
    logic last_m;

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign wr_data  = wr_data_q;
    assign wr_addr  = wr_addr_q;
    assign wr_ena   = wr_ena_q;

    assign hs     = in_valid & in_ready;
    assign last_c = (c_q == cfg_c_q - ONE);
    assign last_r = (r_q == cfg_r_q - ONE);
    assign last_m = (m_q == cfg_m_q - ONE);

    always_comb begin
        state_d     = state_q;
        cfg_m_d     = cfg_m_q;
        cfg_r_d     = cfg_r_q;
        cfg_c_d     = cfg_c_q;
        m_d         = m_q;
        r_d         = r_q;
        c_d         = c_q;
        chan_base_d = chan_base_q;
        row_base_d  = row_base_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        wr_ena_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Oversized dims are clamped so the walk never leaves the tile.
                    cfg_m_d     = (cfg_m > MAX_M) ? MAX_M : cfg_m;
                    cfg_r_d     = (cfg_r > MAX_R) ? MAX_R : cfg_r;
                    cfg_c_d     = (cfg_c > MAX_C) ? MAX_C : cfg_c;
                    m_d         = '0;
                    r_d         = '0;
                    c_d         = '0;
                    chan_base_d = '0;
                    row_base_d  = '0;
                    if (cfg_m == '0 || cfg_r == '0 || cfg_c == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_ena_d  = 1'b1;
                    wr_data_d = in_data;
                    wr_addr_d = chan_base_q + row_base_q + AW'(c_q);
                    if (!last_c) begin
                        c_d = c_q + ONE;
                    end else begin
                        c_d = '0;
                        if (!last_r) begin
                            r_d        = r_q + ONE;
                            row_base_d = row_base_q + ROW_STEP;
                        end else begin
                            r_d         = '0;
                            row_base_d  = '0;
                            m_d         = m_q + ONE;
                            chan_base_d = chan_base_q + CHAN_STEP;
                            if (last_m) begin
                                state_d = FIN;
                            end
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_m_q     <= '0;
            cfg_r_q     <= '0;
            cfg_c_q     <= '0;
            m_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            chan_base_q <= '0;
            row_base_q  <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_ena_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_m_q     <= cfg_m_d;
            cfg_r_q     <= cfg_r_d;
            cfg_c_q     <= cfg_c_d;
            m_q         <= m_d;
            r_q         <= r_d;
            c_q         <= c_d;
            chan_base_q <= chan_base_d;
            row_base_q  <= row_base_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_ena_q    <= wr_ena_d;
        end
    end

endmodule

// File: tb/tb_input_fm_loader.sv
// Directed bench for input_fm_loader with a 4x4x4 tile.
// Writes are logged by a monitor and compared against hand-derived addresses.
module tb_input_fm_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_m = '0;
    logic [15:0] cfg_r = '0;
    logic [15:0] cfg_c = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] wr_data;
    logic [15:0] wr_addr;
    logic        wr_ena;
    logic        busy;
    logic        done;

    input_fm_loader #(
        .AW(16), .DW(32), .Tm(4), .Tr(4), .Tc(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_r(cfg_r), .cfg_c(cfg_c),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_ena(wr_ena),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] la[$];
    logic [31:0] ld[$];
    int          lc[$];
    int          n_done;
    int          done_cyc;
    logic        done_w;
    logic        rdy_seen;
    int          rdy_drop;
    int          s_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (wr_ena) begin
            la.push_back(wr_addr);
            ld.push_back(wr_data);
            lc.push_back(cyc);
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
            done_w   = wr_ena;
        end
        if (in_ready) rdy_seen = 1'b1;
        if (busy && !done && !in_ready) rdy_drop = rdy_drop + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        la.delete();
        ld.delete();
        lc.delete();
        n_done   = 0;
        done_cyc = -1;
        done_w   = 1'b0;
        rdy_seen = 1'b0;
        rdy_drop = 0;
    endtask

    task automatic begin_tile(input int m, input int r, input int c);
        @(negedge clk);
        cfg_m = 16'(m);
        cfg_r = 16'(r);
        cfg_c = 16'(c);
        start = 1'b1;
        s_cyc = cyc + 1;
    endtask

    task automatic stream(input int total, input bit alt,
                          input int restart_at, input int stop_at);
        int  k = 0;
        int  step = 0;
        bit  fired = 1'b0;
        while (k < total && k != stop_at && step < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (k == restart_at && !fired) begin
                start = 1'b1;
                cfg_m = 16'd1;
                fired = 1'b1;
            end
            in_valid = alt ? (step % 2 == 0) : 1'b1;
            in_data  = 32'(k);
            if (in_valid && in_ready) k++;
            step++;
        end
        chk("stream_budget", 32'(step < 2000), 32'd1);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    logic [15:0] part_addr [12] = '{
        16'd0, 16'd1, 16'd4, 16'd5, 16'd8, 16'd9,
        16'd16, 16'd17, 16'd20, 16'd21, 16'd24, 16'd25
    };

    initial begin
        clear_log();
        #2;
        chk("rst_wr_ena", 32'(wr_ena), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // full tile, continuous stream
        clear_log();
        begin_tile(4, 4, 4);
        stream(64, 1'b0, -1, -1);
        drain();
        chk("full_count", 32'(la.size()), 32'd64);
        if (la.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("full_addr", 32'(la[i]), 32'(i));
                chk("full_data", ld[i], 32'(la[i]));
                if (i > 0) chk("full_gap", 32'(lc[i] - lc[i-1]), 32'd1);
            end
            chk("full_done_cyc", 32'(done_cyc), 32'(lc[63]));
        end
        chk("full_done_cnt", 32'(n_done), 32'd1);
        chk("full_done_w", 32'(done_w), 32'd1);
        chk("full_latency", 32'(done_cyc - s_cyc <= 66), 32'd1);

        // partial tile 2x3x2
        clear_log();
        begin_tile(2, 3, 2);
        stream(12, 1'b0, -1, -1);
        drain();
        chk("part_count", 32'(la.size()), 32'd12);
        if (la.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("part_addr", 32'(la[i]), 32'(part_addr[i]));
                chk("part_data", ld[i], 32'(i));
            end
        end
        chk("part_done_cnt", 32'(n_done), 32'd1);
        chk("part_done_w", 32'(done_w), 32'd1);

        // valid toggling
        clear_log();
        begin_tile(4, 4, 4);
        stream(64, 1'b1, -1, -1);
        drain();
        chk("alt_count", 32'(la.size()), 32'd64);
        if (la.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("alt_addr", 32'(la[i]), 32'(i));
                if (i > 0) chk("alt_gap", 32'(lc[i] - lc[i-1]), 32'd2);
            end
        end
        chk("alt_ready_drop", 32'(rdy_drop), 32'd0);
        chk("alt_done_cnt", 32'(n_done), 32'd1);

        // zero-dim tile
        clear_log();
        begin_tile(4, 0, 4);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        drain();
        in_valid = 1'b0;
        chk("zero_count", 32'(la.size()), 32'd0);
        chk("zero_done_cnt", 32'(n_done), 32'd1);
        chk("zero_done_cyc", 32'(done_cyc), 32'(s_cyc));
        chk("zero_ready", 32'(rdy_seen), 32'd0);

        // clamped cfg_m with an ignored mid-load start
        clear_log();
        begin_tile(9, 4, 4);
        stream(64, 1'b0, 20, -1);
        drain();
        chk("clamp_count", 32'(la.size()), 32'd64);
        if (la.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("clamp_addr", 32'(la[i]), 32'(i));
                if (i > 0) chk("clamp_gap", 32'(lc[i] - lc[i-1]), 32'd1);
            end
        end
        chk("clamp_done_cnt", 32'(n_done), 32'd1);

        // reset mid-load
        clear_log();
        begin_tile(4, 4, 4);
        stream(64, 1'b0, -1, 10);
        chk("mid_count", 32'(la.size()), 32'd10);
        rst = 1'b1;
        #1;
        chk("mid_wr_ena", 32'(wr_ena), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_wr_data", wr_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        begin_tile(1, 1, 2);
        stream(2, 1'b0, -1, -1);
        drain();
        chk("post_count", 32'(la.size()), 32'd2);
        if (la.size() == 2) begin
            chk("post_addr0", 32'(la[0]), 32'd0);
            chk("post_addr1", 32'(la[1]), 32'd1);
        end
        chk("post_done_cnt", 32'(n_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
